// File: rtl/mips_pkg.sv
// ============================================================================
// Module   : mips_pkg
// Brief    : Shared MIPS encodings: MULT/DIV op codes and muldiv FSM states.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } mdState_t;

endpackage

`default_nettype wire

// File: rtl/muldiv_negate.sv
// ============================================================================
// Module   : muldiv_negate
// Brief    : Combinational conditional two's-complement negate.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_negate #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] din,
  input  logic             en,
  output logic [WIDTH-1:0] dout
);

  assign dout = en ? (~din + WIDTH'(1)) : din;

endmodule

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO, 1 bit/cycle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             cancel,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [CNT_W-1:0] c_lastCnt = CNT_W'(WIDTH - 1);

  mdState_t             r_state, w_nextState;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_isDiv, r_negRes, r_signA, r_divZero, r_done;
  logic [WIDTH-1:0]     r_rawA, r_absB, r_hi, r_lo;
  logic [2*WIDTH-1:0]   r_shift;

  logic                 w_signedOp;
  logic [WIDTH-1:0]     w_absA, w_absB;
  logic [WIDTH:0]       w_addA, w_addB, w_sum;
  logic [2*WIDTH-1:0]   w_stepShift;
  logic [WIDTH-1:0]     w_prodHi, w_prodLo, w_fixLo, w_negHi, w_resHi, w_resLo;

  assign w_signedOp = (op == MD_MULT) || (op == MD_DIV);

  muldiv_negate #(.WIDTH(WIDTH)) u_absA (
    .din(opA), .en(w_signedOp & opA[WIDTH-1]), .dout(w_absA)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_absB (
    .din(opB), .en(w_signedOp & opB[WIDTH-1]), .dout(w_absB)
  );

  // One shared adder: divide subtracts from the shifted-up partial remainder,
  // multiply adds to the accumulator before the right shift.
  assign w_addA = r_isDiv ? r_shift[2*WIDTH-1:WIDTH-1] : {1'b0, r_shift[2*WIDTH-1:WIDTH]};
  assign w_addB = {1'b0, r_absB};
  assign w_sum  = w_addA + (w_addB ^ {(WIDTH+1){r_isDiv}}) + {{WIDTH{1'b0}}, r_isDiv};

  always_comb begin
    w_stepShift = r_shift;
    if (r_isDiv) begin
      if (!w_sum[WIDTH])
        w_stepShift = {w_sum[WIDTH-1:0], r_shift[WIDTH-2:0], 1'b1};
      else
        w_stepShift = {r_shift[2*WIDTH-2:0], 1'b0};
    end else begin
      if (r_shift[0])
        w_stepShift = {w_sum, r_shift[WIDTH-1:1]};
      else
        w_stepShift = {1'b0, r_shift[2*WIDTH-1:1]};
    end
  end

  assign w_prodHi = r_shift[2*WIDTH-1:WIDTH];
  assign w_prodLo = r_shift[WIDTH-1:0];

  muldiv_negate #(.WIDTH(WIDTH)) u_fixLo (
    .din(w_prodLo), .en(r_negRes), .dout(w_fixLo)
  );
  muldiv_negate #(.WIDTH(WIDTH)) u_fixHi (
    .din(w_prodHi), .en(r_isDiv ? r_signA : r_negRes), .dout(w_negHi)
  );

  // 64-bit product negate: the carry only reaches HI when LO is zero.
  always_comb begin
    w_resLo = w_fixLo;
    w_resHi = w_negHi;
    if (r_divZero) begin
      w_resLo = '1;
      w_resHi = r_rawA;
    end else if (!r_isDiv && r_negRes && (w_prodLo != '0)) begin
      w_resHi = ~w_prodHi;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nextState = S_RUN;
      S_RUN:   if (r_cnt == c_lastCnt) w_nextState = S_FIX;
      S_FIX:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
    if (cancel) w_nextState = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_isDiv   <= 1'b0;
      r_negRes  <= 1'b0;
      r_signA   <= 1'b0;
      r_divZero <= 1'b0;
      r_done    <= 1'b0;
      r_rawA    <= '0;
      r_absB    <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_shift   <= '0;
    end else begin
      r_done <= 1'b0;
      if (!cancel) begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_isDiv   <= op[1];
              r_negRes  <= w_signedOp & (opA[WIDTH-1] ^ opB[WIDTH-1]);
              r_signA   <= w_signedOp & opA[WIDTH-1];
              r_divZero <= op[1] && (opB == '0);
              r_rawA    <= opA;
              r_absB    <= w_absB;
              r_shift   <= {{WIDTH{1'b0}}, w_absA};
              r_cnt     <= '0;
            end else begin
              if (mthi) r_hi <= opA;
              if (mtlo) r_lo <= opA;
            end
          end
          S_RUN: begin
            r_shift <= w_stepShift;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
          S_FIX: begin
            r_hi   <= w_resHi;
            r_lo   <= w_resLo;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

`default_nettype wire
